uart_transmitter: RTL and testbench

Serialises a parallel byte into a UART frame on a single line: idle-high, one start bit (0), N data bits MSB first, one stop bit (1). Each bit is held for CLKS_PER_BIT clock cycles. The block sits directly upstream of UART_reciever: its bit_out drives the receiver's bit_in. The default timing (4 clocks per bit, 8 data bits, MSB first) matches the receiver's expected frame.

---
 rtl/uart_transmitter.sv | 123 ++++++++++++
 tb/tb_uart_transmitter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_transmitter.sv
// UART transmitter: idle-high line, one start bit, N data bits MSB first,
// one stop bit, each bit held CLKS_PER_BIT clocks. All outputs registered.
module uart_transmitter #(
    parameter int unsigned N            = 8,
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] byte_in,
    input  logic         start_in,
    output logic         busy_out,
    output logic         bit_out,
    output logic         done_out
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_FIRST = IW'(N - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  shreg_q, shreg_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [CW-1:0] clk_cnt_q, clk_cnt_d;
    logic          bit_q, bit_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    // State and output registers; reset aborts any frame with the line high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            idx_q     <= '0;
            clk_cnt_q <= '0;
            bit_q     <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            idx_q     <= idx_d;
            clk_cnt_q <= clk_cnt_d;
            bit_q     <= bit_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Next-state logic; outputs are derived from the next state so that the
    // registered line value lines up with the state it belongs to.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        idx_d     = idx_q;
        clk_cnt_d = clk_cnt_q;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_in) begin
                    shreg_d   = byte_in;
                    idx_d     = '0;
                    clk_cnt_d = '0;
                    state_d   = START;
                end
            end
            START: begin
                if (clk_cnt_q == CLK_LAST) begin
                    clk_cnt_d = '0;
                    idx_d     = IDX_FIRST;
                    state_d   = DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (clk_cnt_q == CLK_LAST) begin
                    clk_cnt_d = '0;
                    shreg_d   = shreg_q << 1;
                    if (idx_q == '0) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q - 1'b1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (clk_cnt_q == CLK_LAST) begin
                    clk_cnt_d = '0;
                    state_d   = IDLE;
                    done_d    = 1'b1;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        unique case (state_d)
            START:   bit_d = 1'b0;
            DATA:    bit_d = shreg_d[N-1];
            default: bit_d = 1'b1;
        endcase
    end

    assign busy_out = busy_q;
    assign bit_out  = bit_q;
    assign done_out = done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter: randomized frames compared
// cycle by cycle against an arithmetic model of the expected line waveform.
module tb_uart_transmitter;

    localparam int unsigned N1 = 8;
    localparam int unsigned C1 = 4;
    localparam int unsigned N2 = 4;
    localparam int unsigned C2 = 2;
    localparam int unsigned FLEN1 = (N1 + 2) * C1;
    localparam int unsigned FLEN2 = (N2 + 2) * C2;

    logic         clk;
    logic         rst;
    logic [N1-1:0] byte1;
    logic         start1;
    logic         busy1, bit1, done1;
    logic [N2-1:0] byte2;
    logic         start2;
    logic         busy2, bit2, done2;

    int n_cmp;
    int n_err;

    uart_transmitter #(.N(N1), .CLKS_PER_BIT(C1)) dut (
        .clk(clk), .reset(rst), .byte_in(byte1), .start_in(start1),
        .busy_out(busy1), .bit_out(bit1), .done_out(done1)
    );

    uart_transmitter #(.N(N2), .CLKS_PER_BIT(C2)) dut_small (
        .clk(clk), .reset(rst), .byte_in(byte2), .start_in(start2),
        .busy_out(busy2), .bit_out(bit2), .done_out(done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected line value k cycles into a frame (k = 0 is the first START cycle).
    function automatic logic exp_bit(input int unsigned k, input int unsigned n,
                                     input int unsigned cpb, input logic [7:0] b);
        int unsigned slot;
        slot = k / cpb;
        if (slot == 0) return 1'b0;
        if (slot <= n) return b[n - slot];
        return 1'b1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_check(input int unsigned cycles, input string tag);
        for (int unsigned i = 0; i < cycles; i++) begin
            n_cmp++;
            if ({bit1, busy1, done1} !== 3'b100) begin
                n_err++;
                $display("FAIL %s idle cyc%0d: bit/busy/done=%b%b%b want 100",
                         tag, i, bit1, busy1, done1);
            end
            tick();
        end
    endtask

    // Sends one frame on the wide DUT and checks every cycle plus the done cycle.
    // On return the bench sits in the done cycle with start_in low.
    task automatic send_frame(input logic [7:0] b, input bit noisy, input string tag);
        int unsigned busy_cnt;
        busy_cnt = 0;
        byte1  = b;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int unsigned k = 0; k < FLEN1; k++) begin
            n_cmp++;
            if (bit1 !== exp_bit(k, N1, C1, b) || done1 !== 1'b0) begin
                n_err++;
                $display("FAIL %s byte=%h cyc%0d: bit=%b done=%b want bit=%b done=0",
                         tag, b, k, bit1, done1, exp_bit(k, N1, C1, b));
            end
            if (busy1 === 1'b1) busy_cnt++;
            if (noisy) begin
                start1 = 1'($urandom_range(0, 1));
                byte1  = (k % 2 == 0) ? 8'hFF : 8'($urandom);
            end
            tick();
        end
        start1 = 1'b0;
        n_cmp++;
        if (busy_cnt != FLEN1) begin
            n_err++;
            $display("FAIL %s busy_len: got %0d want %0d", tag, busy_cnt, FLEN1);
        end
        n_cmp++;
        if ({bit1, busy1, done1} !== 3'b101) begin
            n_err++;
            $display("FAIL %s done_cycle: bit/busy/done=%b%b%b want 101",
                     tag, bit1, busy1, done1);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start1 = 1'b0;
        start2 = 1'b0;
        byte1 = '0;
        byte2 = '0;
        #12;
        n_cmp++;
        if ({bit1, busy1, done1} !== 3'b100) begin
            n_err++;
            $display("FAIL reset_state: bit/busy/done=%b%b%b want 100", bit1, busy1, done1);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        idle_check(20, "post_reset");
    endtask

    task automatic test_pattern();
        send_frame(8'b1001_0101, 1'b0, "pattern");
        tick();
        idle_check(3, "after_pattern");
    endtask

    task automatic test_back_to_back();
        logic [7:0] b;
        send_frame(8'h95, 1'b0, "b2b_first");
        send_frame(8'h3C, 1'b0, "b2b_second");
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom);
            send_frame(b, 1'b0, "b2b_rand");
        end
        tick();
        idle_check(2, "after_b2b");
    endtask

    task automatic test_ignore_busy();
        send_frame(8'h00, 1'b1, "ignore_busy");
        tick();
        idle_check(4, "after_ignore");
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b;
        b = 8'hA7;
        byte1  = b;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        // advance into the fourth data bit period
        for (int unsigned k = 0; k < C1 * 4 + 1; k++) tick();
        n_cmp++;
        if (busy1 !== 1'b1) begin
            n_err++;
            $display("FAIL midframe_busy: busy=%b want 1", busy1);
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({bit1, busy1, done1} !== 3'b100) begin
            n_err++;
            $display("FAIL async_reset: bit/busy/done=%b%b%b want 100", bit1, busy1, done1);
        end
        tick();
        rst = 1'b0;
        tick();
        idle_check(C1 * 8, "after_abort");
        send_frame(8'($urandom), 1'b0, "after_reset_frame");
        tick();
        idle_check(2, "after_reset_idle");
    endtask

    task automatic test_random();
        for (int i = 0; i < 10; i++) begin
            send_frame(8'($urandom), 1'($urandom_range(0, 1)), "random");
            if ($urandom_range(0, 1) == 1) begin
                tick();
                idle_check($urandom_range(1, 5), "random_gap");
            end
        end
        tick();
        idle_check(2, "after_random");
    endtask

    task automatic test_small();
        logic [7:0] b;
        int unsigned busy_cnt;
        b = 8'b0000_1010;
        busy_cnt = 0;
        byte2  = b[N2-1:0];
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int unsigned k = 0; k < FLEN2; k++) begin
            n_cmp++;
            if (bit2 !== exp_bit(k, N2, C2, b)) begin
                n_err++;
                $display("FAIL small cyc%0d: bit=%b want %b", k, bit2, exp_bit(k, N2, C2, b));
            end
            if (busy2 === 1'b1) busy_cnt++;
            tick();
        end
        n_cmp++;
        if (busy_cnt != FLEN2) begin
            n_err++;
            $display("FAIL small busy_len: got %0d want %0d", busy_cnt, FLEN2);
        end
        n_cmp++;
        if ({bit2, busy2, done2} !== 3'b101) begin
            n_err++;
            $display("FAIL small done_cycle: bit/busy/done=%b%b%b want 101", bit2, busy2, done2);
        end
        tick();
        n_cmp++;
        if ({bit2, busy2, done2} !== 3'b100) begin
            n_err++;
            $display("FAIL small idle: bit/busy/done=%b%b%b want 100", bit2, busy2, done2);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_pattern();
        test_back_to_back();
        test_ignore_busy();
        test_reset_mid_frame();
        test_random();
        test_small();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
